servisia_mem_ctrl: RTL and testbench

Parametrised external-memory controller for the servisia SoC. It sits between the core's word-wide request/acknowledge bus and the shared 8-bit flash/SRAM data bus. Each word access is split into byte beats. Per-region wait states are programmable, and all strobes are registered (no clock gating of chip selects). Write data goes out on a separate bus with an explicit drive enable for the external tristate buffers.

---
 rtl/servisia_mem_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_servisia_mem_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/servisia_mem_ctrl.sv
// servisia_mem_ctrl: word-wide request/ack bus to shared 8-bit flash/SRAM bus.
// Each core word is split into byte beats (SETUP, ACCESS x (W+1), RECOV).
// Optional build macro: SERVISIA_MEM_FLASH_WRITE_EN enables flash-region writes;
// when undefined, flash writes are acknowledged without touching the bus.
module servisia_mem_ctrl #(
   parameter int WORD_BYTES = 4,
   parameter int ADDR_WIDTH = 21,
   parameter int FLASH_WAIT = 2,
   parameter int SRAM_WAIT  = 0
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    req_i,
   input  logic                    we_i,
   input  logic [ADDR_WIDTH-1:0]   addr_i,
   input  logic [8*WORD_BYTES-1:0] wdata_i,
   input  logic [WORD_BYTES-1:0]   sel_i,
   output logic                    ack_o,
   output logic [8*WORD_BYTES-1:0] rdata_o,
   output logic [ADDR_WIDTH-1:0]   mem_addr_o,
   output logic [7:0]              mem_wdata_o,
   output logic                    mem_drive_o,
   input  logic [7:0]              mem_rdata_i,
   output logic                    flash_ce_no,
   output logic                    sram_cs_no,
   output logic                    mem_we_no,
   output logic                    mem_oe_no
);

   localparam int OFF_W  = $clog2(WORD_BYTES);
   localparam int BEAT_W = (OFF_W == 0) ? 1 : OFF_W;
   localparam int DATA_W = 8 * WORD_BYTES;
   localparam logic [ADDR_WIDTH-1:0] BASE_MASK = ~ADDR_WIDTH'(WORD_BYTES - 1);

   // One extra bit so "no further beat" can be encoded as WORD_BYTES.
   typedef logic [BEAT_W:0] beat_ext_t;
   localparam beat_ext_t NO_BEAT = beat_ext_t'(WORD_BYTES);

`ifdef SERVISIA_MEM_FLASH_WRITE_EN
   localparam bit FLASH_WR_EN = 1'b1;
`else
   localparam bit FLASH_WR_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      ACCESS,
      RECOV,
      ACK
   } state_t;

   // Lowest beat index >= from whose mask bit is set, or NO_BEAT.
   function automatic beat_ext_t first_beat(input logic [WORD_BYTES-1:0] mask,
                                            input beat_ext_t from);
      beat_ext_t res;
      res = NO_BEAT;
      for (int unsigned i = 0; i < WORD_BYTES; i++) begin
         if (res == NO_BEAT && mask[i] && beat_ext_t'(i) >= from) begin
            res = beat_ext_t'(i);
         end
      end
      return res;
   endfunction

   state_t                  state_q, state_d;
   logic                    we_q, we_d;
   logic                    sram_q, sram_d;
   logic [ADDR_WIDTH-1:0]   base_q, base_d;
   logic [DATA_W-1:0]       wdata_q, wdata_d;
   logic [WORD_BYTES-1:0]   mask_q, mask_d;
   logic [BEAT_W-1:0]       beat_q, beat_d;
   logic [3:0]              wait_q, wait_d;
   logic [3:0]              cnt_q, cnt_d;
   logic [DATA_W-1:0]       lanes_q, lanes_d;
   beat_ext_t               nxt;

   logic                    ack_d;
   logic [DATA_W-1:0]       rdata_d;
   logic [ADDR_WIDTH-1:0]   maddr_d;
   logic [7:0]              mwdata_d;
   logic                    drive_d;
   logic                    fce_d;
   logic                    scs_d;
   logic                    mwe_d;
   logic                    moe_d;

   // State and transaction context registers.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         sram_q  <= 1'b0;
         base_q  <= '0;
         wdata_q <= '0;
         mask_q  <= '0;
         beat_q  <= '0;
         wait_q  <= '0;
         cnt_q   <= '0;
         lanes_q <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         sram_q  <= sram_d;
         base_q  <= base_d;
         wdata_q <= wdata_d;
         mask_q  <= mask_d;
         beat_q  <= beat_d;
         wait_q  <= wait_d;
         cnt_q   <= cnt_d;
         lanes_q <= lanes_d;
      end
   end

   // Next-state logic; bus outputs are derived from the next state so that
   // registering them lines the strobes up with the state they belong to.
   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      sram_d   = sram_q;
      base_d   = base_q;
      wdata_d  = wdata_q;
      mask_d   = mask_q;
      beat_d   = beat_q;
      wait_d   = wait_q;
      cnt_d    = cnt_q;
      lanes_d  = lanes_q;
      nxt      = NO_BEAT;

      case (state_q)
         IDLE: begin
            if (req_i) begin
               we_d    = we_i;
               sram_d  = addr_i[ADDR_WIDTH-1];
               base_d  = addr_i & BASE_MASK;
               wdata_d = wdata_i;
               mask_d  = we_i ? sel_i : '1;
               wait_d  = addr_i[ADDR_WIDTH-1] ? 4'(SRAM_WAIT) : 4'(FLASH_WAIT);
               nxt     = first_beat(mask_d, '0);
               if (nxt == NO_BEAT || (we_i && !addr_i[ADDR_WIDTH-1] && !FLASH_WR_EN)) begin
                  state_d = ACK;
               end else begin
                  state_d = SETUP;
                  beat_d  = nxt[BEAT_W-1:0];
               end
            end
         end
         SETUP: begin
            state_d = ACCESS;
            cnt_d   = '0;
         end
         ACCESS: begin
            if (cnt_q == wait_q) begin
               state_d = RECOV;
               if (!we_q) begin
                  lanes_d[beat_q*8 +: 8] = mem_rdata_i;
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         RECOV: begin
            nxt = first_beat(mask_q, beat_ext_t'(beat_q) + beat_ext_t'(1));
            if (nxt == NO_BEAT) begin
               state_d = ACK;
            end else begin
               state_d = SETUP;
               beat_d  = nxt[BEAT_W-1:0];
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      ack_d    = (state_d == ACK);
      rdata_d  = rdata_o;
      maddr_d  = mem_addr_o;
      mwdata_d = mem_wdata_o;
      if (state_d == ACK && !we_d) begin
         rdata_d = lanes_q;
      end
      if (state_d == SETUP) begin
         maddr_d = base_d + ADDR_WIDTH'(beat_d);
         if (we_d) begin
            mwdata_d = wdata_d[beat_d*8 +: 8];
         end
      end
      drive_d = we_d && (state_d == SETUP || state_d == ACCESS || state_d == RECOV);
      fce_d   = !(!sram_d && (state_d == SETUP || state_d == ACCESS));
      scs_d   = !( sram_d && (state_d == SETUP || state_d == ACCESS));
      moe_d   = !(!we_d && state_d == ACCESS);
      mwe_d   = !( we_d && state_d == ACCESS);
   end

   // Registered outputs.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         ack_o       <= 1'b0;
         rdata_o     <= '0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         mem_drive_o <= 1'b0;
         flash_ce_no <= 1'b1;
         sram_cs_no  <= 1'b1;
         mem_we_no   <= 1'b1;
         mem_oe_no   <= 1'b1;
      end else begin
         ack_o       <= ack_d;
         rdata_o     <= rdata_d;
         mem_addr_o  <= maddr_d;
         mem_wdata_o <= mwdata_d;
         mem_drive_o <= drive_d;
         flash_ce_no <= fce_d;
         sram_cs_no  <= scs_d;
         mem_we_no   <= mwe_d;
         mem_oe_no   <= moe_d;
      end
   end

endmodule

// File: tb/tb_servisia_mem_ctrl.sv
// Directed bench for servisia_mem_ctrl with default parameters.
module tb_servisia_mem_ctrl;

   localparam int WB = 4;
   localparam int AW = 21;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req = 1'b0;
   logic          we = 1'b0;
   logic [AW-1:0] addr = '0;
   logic [DW-1:0] wdata = '0;
   logic [WB-1:0] sel = '0;
   logic          ack;
   logic [DW-1:0] rdata;
   logic [AW-1:0] maddr;
   logic [7:0]    mwdata;
   logic          drive;
   logic [7:0]    mrdata;
   logic          fce, scs, mwe, moe;

   logic [7:0]    sram [0:15];

   int checks = 0;
   int failures = 0;
   int cyc, ack_cyc, ack_cnt, we_pulses, we_cycles, oe_cycles, fce_cycles, scs_cycles, drv_cycles;
   logic [AW-1:0] p_addr [2];
   logic [7:0]    p_data [2];
   logic          prev_we;
   logic          cur_we = 1'b0;

   servisia_mem_ctrl #(
      .WORD_BYTES(WB),
      .ADDR_WIDTH(AW),
      .FLASH_WAIT(2),
      .SRAM_WAIT(0)
   ) dut (
      .clk_i(clk),
      .rst_ni(rst_n),
      .req_i(req),
      .we_i(we),
      .addr_i(addr),
      .wdata_i(wdata),
      .sel_i(sel),
      .ack_o(ack),
      .rdata_o(rdata),
      .mem_addr_o(maddr),
      .mem_wdata_o(mwdata),
      .mem_drive_o(drive),
      .mem_rdata_i(mrdata),
      .flash_ce_no(fce),
      .sram_cs_no(scs),
      .mem_we_no(mwe),
      .mem_oe_no(moe)
   );

   always #5 clk = ~clk;

   // Flash returns 0x11*(addr[1:0]+1); SRAM is a small array written by the bench.
   assign mrdata = !scs ? sram[maddr[3:0]] : (8'h11 * ({6'b0, maddr[1:0]} + 8'd1));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clr_mon();
      cyc = 0; ack_cyc = -1; ack_cnt = 0; we_pulses = 0; we_cycles = 0;
      oe_cycles = 0; fce_cycles = 0; scs_cycles = 0; drv_cycles = 0;
      p_addr[0] = '0; p_addr[1] = '0; p_data[0] = '0; p_data[1] = '0;
      prev_we = mwe;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      chk("never_both_selects", (fce === 1'b0 && scs === 1'b0), 1'b0);
      chk("never_oe_and_we", (moe === 1'b0 && mwe === 1'b0), 1'b0);
      chk("never_drive_on_read", (drive === 1'b1 && !cur_we), 1'b0);
      if (ack === 1'b1) begin
         ack_cnt++;
         if (ack_cyc < 0) ack_cyc = cyc;
      end
      if (mwe === 1'b0) begin
         we_cycles++;
         if (prev_we !== 1'b0) begin
            if (we_pulses < 2) begin
               p_addr[we_pulses] = maddr;
               p_data[we_pulses] = mwdata;
            end
            we_pulses++;
         end
         if (scs === 1'b0) sram[maddr[3:0]] = mwdata;
      end
      prev_we = mwe;
      if (moe === 1'b0) oe_cycles++;
      if (fce === 1'b0) fce_cycles++;
      if (scs === 1'b0) scs_cycles++;
      if (drive === 1'b1) drv_cycles++;
   endtask

   // Issue one request, hold it until ack (bounded), then let the FSM return to IDLE.
   task automatic run(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [WB-1:0] s, input int budget);
      clr_mon();
      cur_we = w; we = w; addr = a; wdata = d; sel = s; req = 1'b1;
      while (ack_cyc < 0 && cyc < budget) tick();
      req = 1'b0;
      tick();
      chk("ack_single_cycle", ack, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) sram[i] = 8'h00;

      // Reset held 3 cycles with a pending request.
      rst_n = 1'b0; req = 1'b1; we = 1'b0; addr = 21'h000010;
      clr_mon();
      repeat (3) tick();
      chk("rst_ack", ack, 1'b0);
      chk("rst_ack_count", ack_cnt, 0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_addr", maddr, 21'h0);
      chk("rst_wdata", mwdata, 8'h00);
      chk("rst_drive", drive, 1'b0);
      chk("rst_strobes", {fce, scs, mwe, moe}, 4'b1111);
      rst_n = 1'b1; req = 1'b0;
      tick();

      // Flash read, 4 beats of 5 cycles.
      run(1'b0, 21'h000010, 32'h0, 4'h0, 40);
      chk("frd_ack_cycle", ack_cyc, 21);
      chk("frd_rdata", rdata, 32'h44332211);
      chk("frd_oe_cycles", oe_cycles, 12);
      chk("frd_ce_cycles", fce_cycles, 16);
      chk("frd_cs_cycles", scs_cycles, 0);
      chk("frd_we_cycles", we_cycles, 0);

      // SRAM partial write, beats 0 and 2 only.
      run(1'b1, 21'h100004, 32'hAABBCCDD, 4'b0101, 20);
      chk("swr_ack_cycle", ack_cyc, 7);
      chk("swr_pulses", we_pulses, 2);
      chk("swr_p0_addr", p_addr[0], 21'h100004);
      chk("swr_p0_data", p_data[0], 8'hDD);
      chk("swr_p1_addr", p_addr[1], 21'h100006);
      chk("swr_p1_data", p_data[1], 8'hBB);
      chk("swr_we_cycles", we_cycles, 2);
      chk("swr_drive_cycles", drv_cycles, 6);
      chk("swr_ce_cycles", fce_cycles, 0);
      chk("swr_rdata_held", rdata, 32'h44332211);

      // SRAM write with no byte enables.
      run(1'b1, 21'h100008, 32'h12345678, 4'b0000, 10);
      chk("sel0_ack_cycle", ack_cyc, 1);
      chk("sel0_cs_cycles", scs_cycles, 0);
      chk("sel0_we_cycles", we_cycles, 0);
      chk("sel0_drive_cycles", drv_cycles, 0);

      // Flash write.
      run(1'b1, 21'h000020, 32'h5A5A5A5A, 4'b1111, 40);
`ifdef SERVISIA_MEM_FLASH_WRITE_EN
      chk("fwr_ack_cycle", ack_cyc, 21);
      chk("fwr_pulses", we_pulses, 4);
      chk("fwr_we_cycles", we_cycles, 12);
      chk("fwr_p0_data", p_data[0], 8'h5A);
      chk("fwr_ce_cycles", fce_cycles, 16);
`else
      chk("fwr_ack_cycle", ack_cyc, 1);
      chk("fwr_ce_cycles", fce_cycles, 0);
      chk("fwr_we_cycles", we_cycles, 0);
      chk("fwr_drive_cycles", drv_cycles, 0);
`endif

      // Fill a full SRAM word.
      run(1'b1, 21'h100008, 32'h87654321, 4'b1111, 30);
      chk("fill_ack_cycle", ack_cyc, 13);
      chk("fill_pulses", we_pulses, 4);

      // SRAM read aborted by reset during beat 2.
      clr_mon();
      cur_we = 1'b0; we = 1'b0; addr = 21'h100008; sel = 4'h0; req = 1'b1;
      repeat (7) tick();
      chk("abort_beat2_addr", maddr, 21'h10000A);
      rst_n = 1'b0;
      tick();
      chk("abort_strobes", {fce, scs, mwe, moe}, 4'b1111);
      chk("abort_drive", drive, 1'b0);
      chk("abort_ack", ack, 1'b0);
      chk("abort_rdata", rdata, 32'h0);
      rst_n = 1'b1; req = 1'b0;
      tick();
      chk("abort_no_ack", ack_cnt, 0);

      // Fresh SRAM read after the abort.
      run(1'b0, 21'h100004, 32'h0, 4'h0, 20);
      chk("srd_ack_cycle", ack_cyc, 13);
      chk("srd_rdata", rdata, 32'h00BB00DD);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
